apb_requester: RTL

APB_REQUESTER -- requirements
Module: apb_requester

---
 rtl/apb_requester.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - single-outstanding APB requester: command in, APB transfer, one-cycle response out
// Optional wait-timeout abort is enabled by defining APB_REQ_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module apb_requester #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WRITE,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERRRSP = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic cmd_fire;
  logic cmd_misaligned;
  logic xfer_done;
  logic timeout_hit;

  assign cmd_fire       = CMD_VALID && CMD_READY;
  assign cmd_misaligned = (CMD_ADDR[1:0] != 2'b00);
  // PSELx and PENABLE are both implied by ACCESS, so PREADY alone qualifies completion
  assign xfer_done      = (state == ACCESS) && PREADY;

`ifdef APB_REQ_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;

  // Count stalled ACCESS cycles; the count restarts with every new aligned command
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt <= 8'd0;
    end else if (cmd_fire && !cmd_misaligned) begin
      wait_cnt <= 8'd0;
    end else if ((state == ACCESS) && !PREADY) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // This stalled cycle is the TIMEOUT_CYCLES-th one; a late PREADY still wins
  assign timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          state_nxt = cmd_misaligned ? ERRRSP : SETUP;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (xfer_done || timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      ERRRSP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and APB control outputs decoded from the state
  always_comb begin
    CMD_READY = 1'b0;
    PSELx     = 1'b0;
    PENABLE   = 1'b0;
    case (state)
      IDLE:   CMD_READY = !PRESET;
      SETUP:  PSELx     = 1'b1;
      ACCESS: begin
        PSELx   = 1'b1;
        PENABLE = 1'b1;
      end
      default: begin
        CMD_READY = 1'b0;
      end
    endcase
  end

  // Capture the command onto the APB address/data lines; they hold until the next aligned command
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= 32'd0;
      PWDATA <= 32'd0;
    end else if (cmd_fire && !cmd_misaligned) begin
      PWRITE <= CMD_WRITE;
      PADDR  <= CMD_ADDR;
      PWDATA <= CMD_WDATA;
    end
  end

  // Response pulse plus sticky data/error that persist until the next response
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      RSP_VALID <= 1'b0;
      RSP_RDATA <= 32'd0;
      RSP_ERR   <= 1'b0;
    end else begin
      RSP_VALID <= 1'b0;
      if (xfer_done) begin
        RSP_VALID <= 1'b1;
        RSP_ERR   <= PSLVERR;
        RSP_RDATA <= PWRITE ? 32'd0 : PRDATA;
      end else if (timeout_hit || (state == ERRRSP)) begin
        RSP_VALID <= 1'b1;
        RSP_ERR   <= 1'b1;
        RSP_RDATA <= 32'd0;
      end
    end
  end

endmodule
